// File: rtl/chunked_adder_acc_if.sv
// Operand/result bundle for chunked_adder_acc.
// The master side issues operations and the slave side is the adder.
interface chunked_adder_acc_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;
  logic [WIDTH-1:0] acc;

  modport master (output start, mode, a, b, input busy, done, sum, carry, ovf, acc);
  modport slave  (input start, mode, a, b, output busy, done, sum, carry, ovf, acc);
endinterface

// File: rtl/chunked_adder_acc.sv
// Multi-cycle adder/subtractor with accumulator: CHUNK bits per clock,
// with the carry rippled through a register between cycles.
module chunked_adder_acc #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  chunked_adder_acc_if.slave bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = CHUNK + 1;
  localparam int MSB   = WIDTH - 1;
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N - 1);

  localparam logic [1:0] M_ADD = 2'b00;
  localparam logic [1:0] M_SUB = 2'b01;
  localparam logic [1:0] M_ACC = 2'b10;
  localparam logic [1:0] M_CLR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [1:0]         mode_q, mode_d;
  logic               cy_q, cy_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CW-1:0]      slice_s;
  logic [WIDTH-1:0]   res_s;

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    acc_d    = acc_q;
    k_d      = k_q;
    mode_d   = mode_q;
    cy_d     = cy_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;

    // One chunk of the ripple add, merged into the partial result.
    slice_s = {1'b0, opa_q[k_q*CHUNK +: CHUNK]} + {1'b0, opb_q[k_q*CHUNK +: CHUNK]} + CW'(cy_q);
    res_s   = shadow_q;
    res_s[k_q*CHUNK +: CHUNK] = slice_s[CHUNK-1:0];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d = bus.mode;
          if (bus.mode == M_CLR) begin
            state_d = S_DONE;
            acc_d   = '0;
            sum_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end else begin
            state_d  = S_RUN;
            opa_d    = (bus.mode == M_ACC) ? acc_q : bus.a;
            opb_d    = (bus.mode == M_SUB) ? ~bus.b : bus.b;
            cy_d     = (bus.mode == M_SUB);
            k_d      = '0;
            shadow_d = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        shadow_d = res_s;
        cy_d     = slice_s[CHUNK];
        k_d      = k_q + CNT_W'(1);
        if (k_q == K_LAST) begin
          state_d = S_DONE;
          sum_d   = res_s;
          carry_d = slice_s[CHUNK];
          // opb_q already holds ~b for subtract, so this is the usual sign test.
          ovf_d   = (opa_q[MSB] == opb_q[MSB]) && (res_s[MSB] != opa_q[MSB]);
          if (mode_q != M_SUB) begin
            acc_d = res_s;
          end else begin
            acc_d = acc_q;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      mode_q   <= M_ADD;
      cy_q     <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      mode_q   <= mode_d;
      cy_q     <= cy_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
  assign bus.ovf   = ovf_q;
  assign bus.acc   = acc_q;
endmodule

// File: tb/tb_chunked_adder_acc.sv
// Directed bench for chunked_adder_acc: a CHUNK=2 instance and a CHUNK=8
// instance, expected values worked out by hand from the operand values.
module tb_chunked_adder_acc;
  logic clk;
  logic rst_n;
  logic sel;
  int   n_checks;
  int   n_fail;

  chunked_adder_acc_if #(.WIDTH(8)) if_a ();
  chunked_adder_acc_if #(.WIDTH(8)) if_b ();

  chunked_adder_acc #(.WIDTH(8), .CHUNK(2)) u_dut_c2 (.clk(clk), .rst_n(rst_n), .bus(if_a));
  chunked_adder_acc #(.WIDTH(8), .CHUNK(8)) u_dut_c8 (.clk(clk), .rst_n(rst_n), .bus(if_b));

  logic [31:0] busy_m, done_m, sum_m, carry_m, ovf_m, acc_m;
  assign busy_m  = sel ? {31'd0, if_b.busy}  : {31'd0, if_a.busy};
  assign done_m  = sel ? {31'd0, if_b.done}  : {31'd0, if_a.done};
  assign carry_m = sel ? {31'd0, if_b.carry} : {31'd0, if_a.carry};
  assign ovf_m   = sel ? {31'd0, if_b.ovf}   : {31'd0, if_a.ovf};
  assign sum_m   = sel ? {24'd0, if_b.sum}   : {24'd0, if_a.sum};
  assign acc_m   = sel ? {24'd0, if_b.acc}   : {24'd0, if_a.acc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic st, input logic [1:0] m,
                       input logic [7:0] av, input logic [7:0] bv);
    if (s) begin
      if_b.start = st; if_b.mode = m; if_b.a = av; if_b.b = bv;
    end else begin
      if_a.start = st; if_a.mode = m; if_a.a = av; if_a.b = bv;
    end
  endtask

  // Issue one operation; lat is the cycle (after the start edge) where done is seen.
  task automatic do_op(input logic s, input logic [1:0] m, input logic [7:0] av,
                       input logic [7:0] bv, output int lat, output int bcnt);
    sel = s;
    @(negedge clk);
    drive(s, 1'b1, m, av, bv);
    @(posedge clk);
    lat  = -1;
    bcnt = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 1) drive(s, 1'b0, 2'b00, 8'h00, 8'h00);
      if (done_m[0]) begin
        lat = j;
        break;
      end
      if (busy_m[0]) bcnt++;
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] s, input logic c,
                           input logic o, input logic [7:0] ac);
    check_eq({tag, "_sum"},   sum_m,   {24'd0, s});
    check_eq({tag, "_carry"}, carry_m, {31'd0, c});
    check_eq({tag, "_ovf"},   ovf_m,   {31'd0, o});
    check_eq({tag, "_acc"},   acc_m,   {24'd0, ac});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bcnt, dcnt, first;
    logic [7:0] acc_b [3];
    logic [7:0] acc_e [3];
    acc_b[0] = 8'h10; acc_b[1] = 8'h20; acc_b[2] = 8'h30;
    acc_e[0] = 8'h10; acc_e[1] = 8'h30; acc_e[2] = 8'h60;
    n_checks = 0;
    n_fail   = 0;
    sel      = 1'b0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy_m, 32'd0);
    check_eq("rst_done", done_m, 32'd0);
    check_res("rst", 8'h00, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;

    do_op(1'b0, 2'b00, 8'h7F, 8'h01, lat, bcnt);
    check_eq("add_lat", lat, 32'd5);
    check_eq("add_busy", bcnt, 32'd4);
    check_eq("add_busy_at_done", busy_m, 32'd0);
    check_res("add7f", 8'h80, 1'b0, 1'b1, 8'h80);
    @(negedge clk);
    check_eq("done_one_cycle", done_m, 32'd0);
    check_eq("sum_held", sum_m, 32'h80);

    do_op(1'b0, 2'b01, 8'h05, 8'h07, lat, bcnt);
    check_eq("sub1_lat", lat, 32'd5);
    check_res("sub1", 8'hFE, 1'b0, 1'b0, 8'h80);
    do_op(1'b0, 2'b01, 8'h80, 8'h01, lat, bcnt);
    check_res("sub2", 8'h7F, 1'b1, 1'b1, 8'h80);
    do_op(1'b0, 2'b00, 8'hFF, 8'h01, lat, bcnt);
    check_res("addff", 8'h00, 1'b1, 1'b0, 8'h00);

    do_op(1'b0, 2'b11, 8'h00, 8'h00, lat, bcnt);
    check_eq("clr_lat", lat, 32'd1);
    check_eq("clr_busy", bcnt, 32'd0);
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, 2'b10, 8'hAA, acc_b[i], lat, bcnt);
      check_eq("accum_lat", lat, 32'd5);
      check_eq("accum_acc", acc_m, {24'd0, acc_e[i]});
      check_eq("accum_sum", sum_m, {24'd0, acc_e[i]});
    end
    do_op(1'b0, 2'b11, 8'h00, 8'h00, lat, bcnt);
    check_eq("clr2_lat", lat, 32'd1);
    check_res("clr2", 8'h00, 1'b0, 1'b0, 8'h00);

    // Second start during RUN must be dropped.
    sel = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 8'h12, 8'h34);
    @(posedge clk);
    dcnt  = 0;
    first = -1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 1) drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
      if (j == 2) drive(1'b0, 1'b1, 2'b01, 8'h55, 8'h0F);
      if (j == 3) drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
      if (done_m[0]) begin
        dcnt++;
        if (first < 0) first = j;
      end
    end
    check_eq("ign_done_count", dcnt, 32'd1);
    check_eq("ign_done_at", first, 32'd5);
    check_res("ign", 8'h46, 1'b0, 1'b0, 8'h46);

    // Reset in the second RUN cycle.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 8'h01, 8'h02);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    check_eq("pre_rst_busy", busy_m, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy_m, 32'd0);
    check_eq("mid_rst_done", done_m, 32'd0);
    check_res("mid_rst", 8'h00, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (done_m[0] || busy_m[0]) dcnt++;
    end
    check_eq("post_rst_quiet", dcnt, 32'd0);
    do_op(1'b0, 2'b00, 8'h33, 8'h44, lat, bcnt);
    check_eq("post_rst_lat", lat, 32'd5);
    check_res("post_rst", 8'h77, 1'b0, 1'b0, 8'h77);

    // Single-chunk instance.
    do_op(1'b1, 2'b00, 8'h7F, 8'h01, lat, bcnt);
    check_eq("c8_lat", lat, 32'd2);
    check_eq("c8_busy", bcnt, 32'd1);
    check_res("c8_add", 8'h80, 1'b0, 1'b1, 8'h80);
    do_op(1'b1, 2'b01, 8'h80, 8'h01, lat, bcnt);
    check_eq("c8_sub_lat", lat, 32'd2);
    check_res("c8_sub", 8'h7F, 1'b1, 1'b1, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
